// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: segment patterns
// in {dp,g,f,e,d,c,b,a} order and the display mode encoding.
package seg7_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_BLANK  = 2'b01,
    MODE_LAMP   = 2'b10,
    MODE_NOLZ   = 2'b11
  } mode_e;

  localparam logic [7:0] SEG_0    = 8'h3F;
  localparam logic [7:0] SEG_1    = 8'h06;
  localparam logic [7:0] SEG_2    = 8'h5B;
  localparam logic [7:0] SEG_3    = 8'h4F;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'h6D;
  localparam logic [7:0] SEG_6    = 8'h7D;
  localparam logic [7:0] SEG_7    = 8'h07;
  localparam logic [7:0] SEG_8    = 8'h7F;
  localparam logic [7:0] SEG_9    = 8'h6F;
  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_ALL  = 8'hFF;

endpackage

// File: rtl/seg7_decode.sv
// BCD + decimal point to active-high segment pattern; non-BCD codes show a dash.
// blank suppresses the seven segments but keeps the decimal point.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] pattern
);

  logic [7:0] glyph;

  always_comb begin
    glyph = SEG_DASH;
    case (digit)
      4'd0: glyph = SEG_0;
      4'd1: glyph = SEG_1;
      4'd2: glyph = SEG_2;
      4'd3: glyph = SEG_3;
      4'd4: glyph = SEG_4;
      4'd5: glyph = SEG_5;
      4'd6: glyph = SEG_6;
      4'd7: glyph = SEG_7;
      4'd8: glyph = SEG_8;
      4'd9: glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
    pattern = {dp, blank ? 7'd0 : glyph[6:0]};
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed 7-segment scanner with tear-free shadow digits,
// leading-zero blanking, dead-time between slots and runtime pad polarity.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int PRESCALE   = 1000,
  parameter int DEAD       = 2,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic                    pending,
  input  logic [1:0]              mode,
  input  logic                    seg_pol,
  input  logic                    com_pol,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   com_out,
  output logic [NUM_DIGITS-1:0]   com_oe,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0][3:0] dig_in_v;
  assign dig_in_v = digits_in;

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]  pend_q, pend_d, shad_q, shad_d;
  logic [NUM_DIGITS-1:0]       pend_dp_q, pend_dp_d, shad_dp_q, shad_dp_d;
  logic                        pending_q, pending_d;
  logic [7:0]                  lit_q, lit_d;
  logic [NUM_DIGITS-1:0]       com_act_q, com_act_d;
  logic                        frame_tick_q, frame_tick_d;

  logic                  wrap, boundary, hi_zero, blank_cur;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [7:0]            pattern;
  mode_e                 mode_v;

  assign mode_v = mode_e'(mode);

  seg7_decode u_decode (
    .digit   (shad_q[idx_q]),
    .dp      (shad_dp_q[idx_q]),
    .blank   (blank_cur),
    .pattern (pattern)
  );

  always_comb begin
    wrap     = (cnt_q == CNT_MAX);
    boundary = wrap && (idx_q == IDX_MAX);
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (wrap) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

    pend_d    = pend_q;
    pend_dp_d = pend_dp_q;
    pending_d = pending_q;
    shad_d    = shad_q;
    shad_dp_d = shad_dp_q;
    if (load) begin
      pend_d    = dig_in_v;
      pend_dp_d = dp_in;
      pending_d = 1'b1;
    end
    // Shadow only moves on the frame boundary so a frame is never torn.
    if (boundary) begin
      if (load) begin
        shad_d    = dig_in_v;
        shad_dp_d = dp_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        shad_d    = pend_q;
        shad_dp_d = pend_dp_q;
        pending_d = 1'b0;
      end
    end

    hi_zero  = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hi_zero     = hi_zero && (shad_q[i] == 4'd0);
      lz_blank[i] = (i != 0) && hi_zero;
    end
    blank_cur = BLANK_LZ && (mode_v == MODE_NORMAL) && lz_blank[idx_q];

    case (mode_v)
      MODE_BLANK: lit_d = '0;
      MODE_LAMP:  lit_d = SEG_ALL;
      default:    lit_d = pattern;
    endcase

    com_act_d = '0;
    if ((cnt_q >= CNT_DEAD) && (mode_v != MODE_BLANK)) com_act_d[idx_q] = 1'b1;

    frame_tick_d = (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pending_q    <= 1'b0;
      shad_q       <= '0;
      shad_dp_q    <= '0;
      lit_q        <= '0;
      com_act_q    <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pending_q    <= pending_d;
      shad_q       <= shad_d;
      shad_dp_q    <= shad_dp_d;
      lit_q        <= lit_d;
      com_act_q    <= com_act_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg_out    = seg_pol ? lit_q : ~lit_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;
  assign com_oe     = '1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_com
    assign com_out[g] = com_act_q[g] ? com_pol : ~com_pol;
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 2 digits, 4-cycle slots, 1-cycle dead time.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] digits_in = '0;
  logic [1:0] dp_in = '0;
  logic       load = 1'b0;
  logic       pending;
  logic [1:0] mode = 2'b00;
  logic       seg_pol = 1'b1;
  logic       com_pol = 1'b0;
  logic [7:0] seg_out;
  logic [1:0] com_out;
  logic [1:0] com_oe;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  logic [7:0] fs[8];
  logic [1:0] fc[8];
  logic       fp[8];
  int         tick_wait;

  seg7_scan_driver #(.NUM_DIGITS(2), .PRESCALE(4), .DEAD(1), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .pending(pending), .mode(mode), .seg_pol(seg_pol), .com_pol(com_pol),
    .seg_out(seg_out), .com_out(com_out), .com_oe(com_oe), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Records one full frame starting at the next frame_tick (sampled on negedges).
  task automatic capture_frame();
    tick_wait = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (frame_tick) begin
        tick_wait = n;
        break;
      end
    end
    if (tick_wait == 0) begin
      checks++; errors++;
      $display("FAIL frame_tick_timeout: no tick within 40 cycles");
    end
    fs[0] = seg_out; fc[0] = com_out; fp[0] = pending;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      fs[k] = seg_out; fc[k] = com_out; fp[k] = pending;
    end
  endtask

  task automatic do_load(input logic [7:0] d, input logic [1:0] dp);
    @(negedge clk);
    digits_in = d; dp_in = dp; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  function automatic logic [1:0] exp_com(input int k);
    logic [1:0] e;
    e = 2'b11;
    if ((k % 4) >= 1) e[k / 4] = 1'b0;
    return e;
  endfunction

  task automatic test_reset();
    int gap;
    repeat (3) @(negedge clk);
    checks++; if (seg_out !== 8'h00) begin errors++; $display("FAIL reset_seg got %h want 00", seg_out); end
    checks++; if (com_out !== 2'b11) begin errors++; $display("FAIL reset_com got %b want 11", com_out); end
    checks++; if (com_oe !== 2'b11) begin errors++; $display("FAIL reset_oe got %b want 11", com_oe); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", pending); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", frame_tick); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL first_tick got %b want 1", frame_tick); end
    for (int r = 0; r < 2; r++) begin
      gap = 0;
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk);
        if (frame_tick) begin gap = n; break; end
      end
      checks++; if (gap != 8) begin errors++; $display("FAIL tick_period got %0d want 8", gap); end
    end
  endtask

  task automatic test_load_42();
    do_load(8'h42, 2'b00);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL load42_pending got %b want 1", pending); end
    capture_frame();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (fs[k] !== ((k < 4) ? 8'h5B : 8'h66)) begin
        errors++; $display("FAIL load42_seg[%0d] got %h want %h", k, fs[k], (k < 4) ? 8'h5B : 8'h66);
      end
      checks++;
      if (fc[k] !== exp_com(k) || fc[k] === 2'b00) begin
        errors++; $display("FAIL load42_com[%0d] got %b want %b", k, fc[k], exp_com(k));
      end
    end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL load42_pending_clr got %b want 0", pending); end
  endtask

  task automatic test_lz_blank();
    do_load(8'h07, 2'b00);
    capture_frame();
    checks++; if (fs[1] !== 8'h07) begin errors++; $display("FAIL lz_slot0 got %h want 07", fs[1]); end
    checks++; if (fs[5] !== 8'h00) begin errors++; $display("FAIL lz_slot1 got %h want 00", fs[5]); end
    @(negedge clk);
    mode = 2'b11;
    capture_frame();
    checks++; if (fs[1] !== 8'h07) begin errors++; $display("FAIL nolz_slot0 got %h want 07", fs[1]); end
    checks++; if (fs[5] !== 8'h3F) begin errors++; $display("FAIL nolz_slot1 got %h want 3F", fs[5]); end
    mode = 2'b00;
    capture_frame();
  endtask

  task automatic test_last_wins();
    do_load(8'h3A, 2'b00);
    do_load(8'h15, 2'b00);
    capture_frame();
    checks++; if (fs[2] !== 8'h6D) begin errors++; $display("FAIL lastwins_slot0 got %h want 6D", fs[2]); end
    checks++; if (fs[6] !== 8'h06) begin errors++; $display("FAIL lastwins_slot1 got %h want 06", fs[6]); end
    do_load(8'h0A, 2'b00);
    capture_frame();
    checks++; if (fs[2] !== 8'h40) begin errors++; $display("FAIL dash_slot0 got %h want 40", fs[2]); end
    checks++; if (fs[6] !== 8'h00) begin errors++; $display("FAIL dash_slot1 got %h want 00", fs[6]); end
    do_load(8'h05, 2'b11);
    capture_frame();
    checks++; if (fs[2] !== 8'hED) begin errors++; $display("FAIL dp_slot0 got %h want ED", fs[2]); end
    checks++; if (fs[6] !== 8'h80) begin errors++; $display("FAIL dp_blank_slot1 got %h want 80", fs[6]); end
  endtask

  task automatic test_boundary_load();
    // Called right after a capture: the next edge starts slot 0, so edge 8 is the boundary.
    repeat (7) @(negedge clk);
    digits_in = 8'h93; dp_in = 2'b00; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL bload_pending got %b want 0", pending); end
    capture_frame();
    checks++; if (tick_wait != 1) begin errors++; $display("FAIL bload_same_frame got wait %0d want 1", tick_wait); end
    checks++; if (fs[1] !== 8'h4F) begin errors++; $display("FAIL bload_slot0 got %h want 4F", fs[1]); end
    checks++; if (fs[5] !== 8'h6F) begin errors++; $display("FAIL bload_slot1 got %h want 6F", fs[5]); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (fp[k] !== 1'b0) begin errors++; $display("FAIL bload_pending[%0d] got %b want 0", k, fp[k]); end
    end
  endtask

  task automatic test_modes();
    @(negedge clk);
    mode = 2'b10;
    @(negedge clk);
    checks++; if (seg_out !== 8'hFF) begin errors++; $display("FAIL lamp_next_clk got %h want FF", seg_out); end
    capture_frame();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (fs[k] !== 8'hFF || fc[k] !== exp_com(k)) begin
        errors++; $display("FAIL lamp[%0d] got %h/%b want FF/%b", k, fs[k], fc[k], exp_com(k));
      end
    end
    mode = 2'b01;
    capture_frame();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (fs[k] !== 8'h00 || fc[k] !== 2'b11) begin
        errors++; $display("FAIL blank[%0d] got %h/%b want 00/11", k, fs[k], fc[k]);
      end
    end
    mode = 2'b00;
    capture_frame();
  endtask

  task automatic test_polarity();
    seg_pol = 1'b0; com_pol = 1'b1;
    capture_frame();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (fs[k] !== ((k < 4) ? 8'hB0 : 8'h90) || fc[k] !== ~exp_com(k)) begin
        errors++; $display("FAIL pol[%0d] got %h/%b want %h/%b", k, fs[k], fc[k],
                           (k < 4) ? 8'hB0 : 8'h90, ~exp_com(k));
      end
    end
    seg_pol = 1'b1; com_pol = 1'b0;
  endtask

  task automatic test_reset_mid();
    capture_frame();
    do_load(8'h55, 2'b01);
    repeat (4) @(negedge clk);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rmid_pre_pending got %b want 1", pending); end
    #2 rst = 1'b1;
    #1;
    checks++; if (seg_out !== 8'h00) begin errors++; $display("FAIL rmid_seg got %h want 00", seg_out); end
    checks++; if (com_out !== 2'b11) begin errors++; $display("FAIL rmid_com got %b want 11", com_out); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rmid_pending got %b want 0", pending); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rmid_tick got %b want 0", frame_tick); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    capture_frame();
    checks++; if (fs[2] !== 8'h3F) begin errors++; $display("FAIL rmid_slot0 got %h want 3F", fs[2]); end
    checks++; if (fs[6] !== 8'h00) begin errors++; $display("FAIL rmid_slot1 got %h want 00", fs[6]); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rmid_post_pending got %b want 0", pending); end
  endtask

  initial begin
    test_reset();
    test_load_42();
    test_lz_blank();
    test_last_wins();
    test_boundary_load();
    test_modes();
    test_polarity();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
